// File: rtl/fifo_dff_gen_pkg.sv
// Width derivation and level arithmetic shared by the register-array FIFO and its output stage.
package fifo_dff_gen_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Pointer needs at least one bit even for the smallest legal depth.
  function automatic int ptr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Room for depth+1 words when the output register is present.
  function automatic int lvl_w(input int depth);
    return clog2(depth + 2);
  endfunction

  function automatic int lvl_step(input int lvl, input logic inc, input logic dec);
    if (inc && !dec) return lvl + 1;
    else if (dec && !inc) return lvl - 1;
    else return lvl;
  endfunction

endpackage

// File: rtl/fifo_dff_gen_out_stage.sv
// One-entry prefetch register with valid; loads on load_en, empties on unload unless reloaded the same edge.
// Latency one cycle from load_en to out_vld; never stalls, the parent only loads when the slot is free or being unloaded.
module fifo_dff_gen_out_stage #(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] load_dat,
  input  logic                  unload,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat
);

  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load_en) begin
      vld_d = 1'b1;
      dat_d = load_dat;
    end else if (unload) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
  end

  // Payload is not reset; valid alone qualifies it.
  always_ff @(posedge clk) begin
    dat_q <= dat_d;
  end

  assign out_vld = vld_q;
  assign out_dat = dat_q;

endmodule

// File: rtl/fifo_dff_gen.sv
// Show-ahead register-array FIFO, any depth, level/almost flags, sticky overflow/underflow; FIFO_DFF_GEN_OUT_REG_EN adds an output register.
// Head visible the cycle after push (two with output register); dropped push when full without pop, ignored pop when empty.
module fifo_dff_gen
  import fifo_dff_gen_pkg::*;
#(
  parameter  int DATA_WIDTH = 256,
  parameter  int FIFO_DEPTH = 8,
  parameter  int AFULL_TH   = FIFO_DEPTH - 1,
  parameter  int AEMPTY_TH  = 1,
  localparam int LVL_W      = lvl_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [LVL_W-1:0]      level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int               PTR_W    = ptr_w(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic                  w_ph_q, w_ph_d, r_ph_q, r_ph_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;

  logic                  mem_empty, mem_full, head_vld;
  logic                  push_acc, pop_acc, mem_rd;
  logic [DATA_WIDTH-1:0] mem_head;

  assign mem_empty = (w_ptr_q == r_ptr_q) && (w_ph_q == r_ph_q);
  assign mem_full  = (w_ptr_q == r_ptr_q) && (w_ph_q != r_ph_q);
  assign mem_head  = mem_q[r_ptr_q];

`ifdef FIFO_DFF_GEN_OUT_REG_EN
  // Refill the output register whenever it is free or being consumed this edge.
  assign mem_rd = ~mem_empty & (~head_vld | pop_acc);

  fifo_dff_gen_out_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .clk      (clk),
    .rst      (rst),
    .load_en  (mem_rd),
    .load_dat (mem_head),
    .unload   (pop_acc),
    .out_vld  (head_vld),
    .out_dat  (data_out)
  );
`else
  assign head_vld = ~mem_empty;
  assign mem_rd   = pop_acc;
  assign data_out = mem_head;
`endif

  assign empty    = ~head_vld;
  assign full     = mem_full;
  assign pop_acc  = pop & head_vld;
  assign push_acc = push & (~mem_full | pop_acc);

  always_comb begin
    w_ptr_d     = w_ptr_q;
    w_ph_d      = w_ph_q;
    r_ptr_d     = r_ptr_q;
    r_ph_d      = r_ph_q;
    level_d     = LVL_W'(lvl_step(int'(level_q), push_acc, pop_acc));
    overflow_d  = overflow_q | (push & ~push_acc);
    underflow_d = underflow_q | (pop & ~pop_acc);
    if (push_acc) begin
      if (w_ptr_q == PTR_LAST) begin
        w_ptr_d = '0;
        w_ph_d  = ~w_ph_q;
      end else begin
        w_ptr_d = w_ptr_q + 1'b1;
      end
    end
    if (mem_rd) begin
      if (r_ptr_q == PTR_LAST) begin
        r_ptr_d = '0;
        r_ph_d  = ~r_ph_q;
      end else begin
        r_ptr_d = r_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q     <= '0;
      w_ph_q      <= 1'b0;
      r_ptr_q     <= '0;
      r_ph_q      <= 1'b0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      w_ph_q      <= w_ph_d;
      r_ptr_q     <= r_ptr_d;
      r_ph_q      <= r_ph_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[w_ptr_q] <= data_in;
  end

  assign level        = level_q;
  assign almost_full  = (int'(level_q) >= AFULL_TH);
  assign almost_empty = (int'(level_q) <= AEMPTY_TH);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
